yonga_can_tx_mailbox: RTL and testbench
=======================================

YONGA_CAN_TX_MAILBOX -- requirements
Module: yonga_can_tx_mailbox

Interface
REQ-001 SHALL have parameter NUM_MB, default 4, number of TX mailboxes (legal 1..8).
REQ-002 SHALL have parameter AW, default 8, register address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports reg_valid in 1, reg_ready out 1, reg_wr_en in 1, reg_addr in AW, reg_wstrb in 4, reg_wdata in 32, reg_rdata out 32: CPU register bus.
REQ-006 SHALL have ports tx_req out 1, tx_ack in 1, tx_done in 1, tx_sts in 3: frame handoff to controller/packetizer.
REQ-007 SHALL have ports tx_mb_idx out 3, tx_msg_id out 32, tx_msg_cfg out 32, tx_data out 64: snapshot of selected mailbox.
REQ-008 SHALL have port irq out 1: level interrupt.

Function
REQ-009 Mailbox m (0..NUM_MB-1) SHALL occupy base m*16: +0x0 MSG_ID, +0x4 MSG_CFG, +0x8 DATA1, +0xC DATA2; byte-wise write via reg_wstrb.
REQ-010 Global block at G=NUM_MB*16 SHALL hold: G+0 CTRL (W, reads 0; [7:0] SEND write-1-set, [15:8] ABORT write-1), G+4 STATUS, G+8 IRQ_EN ([7:0] done enable, [15:8] error enable).
REQ-011 STATUS SHALL be: [7:0] pending RO, [15:8] done W1C, [23:16] error W1C, [26:24] last nonzero tx_sts RO, [30:28] in-flight index RO, [31] busy RO.
REQ-012 Bus: reg_ready SHALL pulse high exactly one cycle, the cycle after reg_valid with reg_ready low; reg_rdata SHALL be registered in that same cycle; unmapped reads return 0, unmapped writes ignored.
REQ-013 Writes to a mailbox that is pending or in flight SHALL be ignored; reads still return contents.
REQ-014 SEND/ABORT bits at indices >= NUM_MB SHALL be ignored; ABORT SHALL clear pending only for mailboxes not in flight.
REQ-015 FSM states IDLE, ARB, REQ, WAIT; IDLE->ARB when any pending bit set.
REQ-016 ARB (one cycle): winner = pending mailbox with smallest 30-bit key {MSG_ID[29:19], MSG_ID[18], MSG_ID[17:0]}; tie -> lowest index; latch index and snapshot onto tx_* outputs; ->REQ. If no mailbox is pending (aborted meanwhile) -> IDLE.
REQ-017 REQ: tx_req SHALL be high and tx_* stable until tx_ack sampled high; then ->WAIT with tx_req low the next cycle.
REQ-018 WAIT: on tx_done clear that mailbox's pending bit; tx_sts==0 sets done bit, else sets error bit and latches tx_sts into STATUS[26:24]; ->IDLE.
REQ-019 busy SHALL be high in ARB, REQ and WAIT.
REQ-020 Simultaneous events: a SEND set and a hardware pending clear for the same bit in one cycle -> bit set; a W1C and hardware set of the same done/error bit in one cycle -> bit set.
REQ-021 irq SHALL be registered: |(done & IRQ_EN[7:0]) | |(error & IRQ_EN[15:8]).
REQ-022 tx_done outside WAIT and tx_ack outside REQ SHALL be ignored.

Reset
REQ-023 rst_n low SHALL asynchronously clear all registers, STATUS, IRQ_EN, FSM->IDLE; reg_ready, reg_rdata, tx_req, tx_mb_idx, tx_msg_id, tx_msg_cfg, tx_data, irq = 0.
REQ-024 Reset mid-transfer SHALL drop tx_req immediately and discard the frame; no done or error is recorded.

Verification
REQ-025 Write MB0 MSG_ID=0x0010_0000 with wstrb=4'b0100 only -> readback 0x0010_0000; reg_ready one cycle wide.
REQ-026 MB1 ID[29:19]=0x123, MB2 ID[29:19]=0x100, SEND=0x06 -> MB2 sent first (tx_mb_idx=2), then MB1.
REQ-027 Equal keys in MB0/MB3, SEND=0x09 -> MB0 first; pending=0x08 while MB3 waits.
REQ-028 tx_done with tx_sts=3'b101 -> error[idx] set, STATUS[26:24]=5, irq=1 if enabled; W1C clears it, irq drops.
REQ-029 ABORT=0x03 while MB0 in flight and MB1 pending -> MB1 pending cleared, MB0 completes normally; write to MB0 during flight ignored.
REQ-030 rst_n low during REQ -> tx_req=0 same cycle, STATUS=0 after release.

Source files
------------

// File: rtl/yonga_can_tx_mailbox.sv
// CAN TX mailbox bank: CPU-written mailboxes, ID-priority arbitration,
// frame handoff (tx_req/tx_ack/tx_done), STATUS/IRQ. Ports: reg_* bus, tx_*, irq.
module yonga_can_tx_mailbox #(
  parameter int NUM_MB = 4,
  parameter int AW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reg_valid,
  output logic          reg_ready,
  input  logic          reg_wr_en,
  input  logic [AW-1:0] reg_addr,
  input  logic [3:0]    reg_wstrb,
  input  logic [31:0]   reg_wdata,
  output logic [31:0]   reg_rdata,
  output logic          tx_req,
  input  logic          tx_ack,
  input  logic          tx_done,
  input  logic [2:0]    tx_sts,
  output logic [2:0]    tx_mb_idx,
  output logic [31:0]   tx_msg_id,
  output logic [31:0]   tx_msg_cfg,
  output logic [63:0]   tx_data,
  output logic          irq
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_WAIT} state_e;

  localparam int NW = NUM_MB * 4;
  localparam logic [7:0] MB_MASK = 8'((1 << NUM_MB) - 1);
  localparam logic [AW-3:0] W_CTRL = (AW-2)'(NUM_MB * 4);
  localparam logic [AW-3:0] W_STAT = (AW-2)'(NUM_MB * 4 + 1);
  localparam logic [AW-3:0] W_IREN = (AW-2)'(NUM_MB * 4 + 2);

  logic [31:0] mb_q [NW];
  logic [31:0] mb_d [NW];
  logic [7:0]  pend_q, pend_d, done_q, done_d, err_q, err_d;
  logic [2:0]  sts_q, sts_d, idx_q, idx_d;
  logic [15:0] ien_q, ien_d;
  state_e      st_q, st_d;
  logic [31:0] id_q, id_d, cfg_q, cfg_d;
  logic [63:0] dat_q, dat_d;
  logic        irq_q, irq_d, rdy_q, rdy_d;
  logic [31:0] rdata_q, rdata_d;

  logic          acc, wr, rd, al, busy, flight;
  logic [AW-3:0] waddr;
  logic [7:0]    fl_mask, send, abort_clr, w1c_done, w1c_err;
  logic [7:0]    pend_arb, hw_clr, hw_done, hw_err;
  logic [31:0]   status;
  logic          found;
  logic [2:0]    win;
  logic [29:0]   best;
  logic [31:0]   w_id, w_cfg;
  logic [63:0]   w_dat;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Accept one access per reg_valid; ready is the one-cycle response.
  assign acc     = reg_valid & ~rdy_q;
  assign wr      = acc & reg_wr_en;
  assign rd      = acc & ~reg_wr_en;
  assign al      = (reg_addr[1:0] == 2'b00);
  assign waddr   = reg_addr[AW-1:2];
  assign busy    = (st_q != S_IDLE);
  assign flight  = (st_q == S_REQ) || (st_q == S_WAIT);
  assign fl_mask = flight ? (8'd1 << idx_q) : 8'd0;
  assign status  = {busy, idx_q, 1'b0, sts_q, err_q, done_q, pend_q};

  always_comb begin
    send      = 8'd0;
    abort_clr = 8'd0;
    w1c_done  = 8'd0;
    w1c_err   = 8'd0;
    if (wr && al && waddr == W_CTRL) begin
      if (reg_wstrb[0]) send = reg_wdata[7:0] & MB_MASK;
      if (reg_wstrb[1])
        abort_clr = reg_wdata[15:8] & MB_MASK & ~fl_mask;
    end
    if (wr && al && waddr == W_STAT) begin
      if (reg_wstrb[1]) w1c_done = reg_wdata[15:8];
      if (reg_wstrb[2]) w1c_err  = reg_wdata[23:16];
    end
  end

  // Smallest 30-bit key wins; strict compare keeps the lowest index on ties.
  // Mailboxes aborted this cycle are excluded from arbitration.
  always_comb begin
    pend_arb = pend_q & ~abort_clr;
    found    = 1'b0;
    win      = 3'd0;
    best     = '1;
    w_id     = 32'd0;
    w_cfg    = 32'd0;
    w_dat    = 64'd0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pend_arb[i] && (!found || mb_q[4*i][29:0] < best)) begin
        found = 1'b1;
        win   = 3'(i);
        best  = mb_q[4*i][29:0];
        w_id  = mb_q[4*i];
        w_cfg = mb_q[4*i+1];
        w_dat = {mb_q[4*i+3], mb_q[4*i+2]};
      end
    end
  end

  always_comb begin
    mb_d    = mb_q;
    ien_d   = ien_q;
    st_d    = st_q;
    idx_d   = idx_q;
    id_d    = id_q;
    cfg_d   = cfg_q;
    dat_d   = dat_q;
    sts_d   = sts_q;
    hw_clr  = 8'd0;
    hw_done = 8'd0;
    hw_err  = 8'd0;
    rdy_d   = acc;
    rdata_d = rdata_q;

    if (acc) rdata_d = 32'd0;
    for (int i = 0; i < NW; i++) begin
      if (al && waddr == (AW-2)'(i)) begin
        if (rd) rdata_d = mb_q[i];
        if (wr && !pend_q[i/4] && !fl_mask[i/4])
          mb_d[i] = merge(mb_q[i], reg_wdata, reg_wstrb);
      end
    end
    if (rd && al && waddr == W_STAT) rdata_d = status;
    if (rd && al && waddr == W_IREN) rdata_d = {16'd0, ien_q};
    if (wr && al && waddr == W_IREN) begin
      if (reg_wstrb[0]) ien_d[7:0]  = reg_wdata[7:0];
      if (reg_wstrb[1]) ien_d[15:8] = reg_wdata[15:8];
    end

    unique case (st_q)
      S_IDLE: if (|pend_q) st_d = S_ARB;
      S_ARB: begin
        st_d = S_IDLE;
        if (found) begin
          st_d  = S_REQ;
          idx_d = win;
          id_d  = w_id;
          cfg_d = w_cfg;
          dat_d = w_dat;
        end
      end
      S_REQ: if (tx_ack) st_d = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          st_d   = S_IDLE;
          hw_clr = 8'd1 << idx_q;
          if (tx_sts == 3'd0) hw_done = 8'd1 << idx_q;
          else begin
            hw_err = 8'd1 << idx_q;
            sts_d  = tx_sts;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase

    // Software set beats hardware clear; hardware set beats W1C.
    pend_d = (pend_q & ~hw_clr & ~abort_clr) | send;
    done_d = (done_q & ~w1c_done) | hw_done;
    err_d  = (err_q & ~w1c_err) | hw_err;
    irq_d  = |(done_q & ien_q[7:0]) | |(err_q & ien_q[15:8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) mb_q[i] <= 32'd0;
      pend_q  <= 8'd0;
      done_q  <= 8'd0;
      err_q   <= 8'd0;
      sts_q   <= 3'd0;
      idx_q   <= 3'd0;
      ien_q   <= 16'd0;
      st_q    <= S_IDLE;
      id_q    <= 32'd0;
      cfg_q   <= 32'd0;
      dat_q   <= 64'd0;
      irq_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      mb_q    <= mb_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sts_q   <= sts_d;
      idx_q   <= idx_d;
      ien_q   <= ien_d;
      st_q    <= st_d;
      id_q    <= id_d;
      cfg_q   <= cfg_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
    end
  end

  assign reg_ready  = rdy_q;
  assign reg_rdata  = rdata_q;
  assign tx_req     = (st_q == S_REQ);
  assign tx_mb_idx  = idx_q;
  assign tx_msg_id  = id_q;
  assign tx_msg_cfg = cfg_q;
  assign tx_data    = dat_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_yonga_can_tx_mailbox.sv
// Directed bench for yonga_can_tx_mailbox: bus access, arbitration,
// completion/error, abort and reset behaviour against hand-computed values.
`timescale 1ns/1ps
module tb_yonga_can_tx_mailbox;

  logic        clk, rst_n;
  logic        reg_valid, reg_ready, reg_wr_en;
  logic [7:0]  reg_addr;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_wdata, reg_rdata;
  logic        tx_req, tx_ack, tx_done;
  logic [2:0]  tx_sts, tx_mb_idx;
  logic [31:0] tx_msg_id, tx_msg_cfg;
  logic [63:0] tx_data;
  logic        irq;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] A_CTRL = 8'h40;
  localparam logic [7:0] A_STAT = 8'h44;
  localparam logic [7:0] A_IREN = 8'h48;

  yonga_can_tx_mailbox #(.NUM_MB(4), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_valid(reg_valid), .reg_ready(reg_ready),
    .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wstrb(reg_wstrb), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .tx_req(tx_req), .tx_ack(tx_ack),
    .tx_done(tx_done), .tx_sts(tx_sts),
    .tx_mb_idx(tx_mb_idx), .tx_msg_id(tx_msg_id),
    .tx_msg_cfg(tx_msg_cfg), .tx_data(tx_data),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    int n;
    reg_valid = 1'b1; reg_wr_en = 1'b1;
    reg_addr = a; reg_wdata = d; reg_wstrb = s;
    n = 0;
    do begin cyc(1); n++; end while (!reg_ready && n < 10);
    if (!reg_ready) begin
      failures++;
      $display("FAIL bus_wr_timeout addr=%h", a);
    end
    reg_valid = 1'b0; reg_wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    int n;
    reg_valid = 1'b1; reg_wr_en = 1'b0;
    reg_addr = a; reg_wstrb = 4'h0;
    n = 0;
    do begin cyc(1); n++; end while (!reg_ready && n < 10);
    if (!reg_ready) begin
      failures++;
      $display("FAIL bus_rd_timeout addr=%h", a);
    end
    d = reg_rdata;
    reg_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!tx_req && n < 20) begin cyc(1); n++; end
    if (!tx_req) begin
      failures++;
      $display("FAIL tx_req_timeout");
    end
  endtask

  task automatic finish_tx(input logic [2:0] s);
    tx_ack = 1'b1; cyc(1); tx_ack = 1'b0;
    tx_done = 1'b1; tx_sts = s; cyc(1);
    tx_done = 1'b0; tx_sts = 3'd0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    cyc(3);
    checks++;
    if ({reg_ready, tx_req, irq} !== 3'b000) begin
      failures++;
      $display("FAIL rst_ctl got=%b exp=000", {reg_ready, tx_req, irq});
    end
    checks++;
    if ({reg_rdata, tx_msg_id, tx_data} !== 128'd0) begin
      failures++;
      $display("FAIL rst_data got=%h exp=0", {reg_rdata, tx_msg_id, tx_data});
    end
    rst_n = 1'b1;
    cyc(1);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rst_status got=%h exp=00000000", d);
    end
  endtask

  task automatic test_byte_write();
    bus_wr(8'h00, 32'hFF10_FFFF, 4'b0100);
    cyc(1);
    reg_valid = 1'b1; reg_wr_en = 1'b0; reg_addr = 8'h00;
    cyc(1);
    checks++;
    if (reg_ready !== 1'b1 || reg_rdata !== 32'h0010_0000) begin
      failures++;
      $display("FAIL byte_wr got=%b/%h exp=1/00100000", reg_ready, reg_rdata);
    end
    reg_valid = 1'b0;
    cyc(1);
    checks++;
    if (reg_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_width got=%b exp=0", reg_ready);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    bus_wr(8'h4C, 32'hFFFF_FFFF, 4'hF);
    bus_rd(8'h4C, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL unmapped_rd got=%h exp=00000000", d);
    end
    bus_wr(A_CTRL, 32'h0000_00F0, 4'b0001);
    tx_done = 1'b1; tx_sts = 3'd3;
    cyc(1);
    tx_done = 1'b0; tx_sts = 3'd0;
    cyc(4);
    checks++;
    if (tx_req !== 1'b0) begin
      failures++;
      $display("FAIL send_oor got=%b exp=0", tx_req);
    end
    bus_rd(A_CTRL, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL ctrl_rd got=%h exp=00000000", d);
    end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL idle_done_ign got=%h exp=00000000", d);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bus_wr(8'h10, 32'h0918_0000, 4'hF);
    bus_wr(8'h20, 32'h0800_0000, 4'hF);
    bus_wr(8'h24, 32'h0000_0008, 4'hF);
    bus_wr(8'h28, 32'h1122_3344, 4'hF);
    bus_wr(8'h2C, 32'h5566_7788, 4'hF);
    bus_wr(A_CTRL, 32'h0000_0006, 4'b0001);
    wait_req();
    checks++;
    if (tx_mb_idx !== 3'd2 || tx_msg_id !== 32'h0800_0000) begin
      failures++;
      $display("FAIL prio_first got=%0d/%h exp=2/08000000", tx_mb_idx, tx_msg_id);
    end
    checks++;
    if (tx_msg_cfg !== 32'h8 || tx_data !== 64'h5566_7788_1122_3344) begin
      failures++;
      $display("FAIL snapshot got=%h/%h", tx_msg_cfg, tx_data);
    end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'hA000_0006) begin
      failures++;
      $display("FAIL status_req got=%h exp=a0000006", d);
    end
    tx_ack = 1'b1; cyc(1); tx_ack = 1'b0;
    checks++;
    if (tx_req !== 1'b0) begin
      failures++;
      $display("FAIL req_drop got=%b exp=0", tx_req);
    end
    tx_done = 1'b1; cyc(1); tx_done = 1'b0;
    wait_req();
    checks++;
    if (tx_mb_idx !== 3'd1 || tx_msg_id !== 32'h0918_0000) begin
      failures++;
      $display("FAIL prio_second got=%0d/%h exp=1/09180000", tx_mb_idx, tx_msg_id);
    end
    finish_tx(3'd0);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h1000_0600) begin
      failures++;
      $display("FAIL done_bits got=%h exp=10000600", d);
    end
    bus_wr(A_STAT, 32'h0000_0600, 4'b0010);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h1000_0000) begin
      failures++;
      $display("FAIL done_w1c got=%h exp=10000000", d);
    end
  endtask

  task automatic test_tie();
    logic [31:0] d;
    bus_wr(8'h00, 32'h00AA_0000, 4'hF);
    bus_wr(8'h30, 32'h00AA_0000, 4'hF);
    bus_wr(A_CTRL, 32'h0000_0009, 4'b0001);
    wait_req();
    checks++;
    if (tx_mb_idx !== 3'd0) begin
      failures++;
      $display("FAIL tie_first got=%0d exp=0", tx_mb_idx);
    end
    finish_tx(3'd0);
    bus_rd(A_STAT, d);
    checks++;
    if (d[7:0] !== 8'h08) begin
      failures++;
      $display("FAIL tie_pend got=%h exp=08", d[7:0]);
    end
    wait_req();
    checks++;
    if (tx_mb_idx !== 3'd3) begin
      failures++;
      $display("FAIL tie_second got=%0d exp=3", tx_mb_idx);
    end
    finish_tx(3'd0);
    bus_wr(A_STAT, 32'h0000_0900, 4'b0010);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h3000_0000) begin
      failures++;
      $display("FAIL tie_status got=%h exp=30000000", d);
    end
  endtask

  task automatic test_error();
    logic [31:0] d;
    bus_wr(A_IREN, 32'h0000_FF00, 4'b0011);
    bus_wr(A_CTRL, 32'h0000_0002, 4'b0001);
    wait_req();
    finish_tx(3'b101);
    cyc(2);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL err_irq got=%b exp=1", irq);
    end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h1502_0000) begin
      failures++;
      $display("FAIL err_status got=%h exp=15020000", d);
    end
    bus_wr(A_STAT, 32'h0002_0000, 4'b0100);
    cyc(2);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL err_irq_clr got=%b exp=0", irq);
    end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h1500_0000) begin
      failures++;
      $display("FAIL err_w1c got=%h exp=15000000", d);
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    bus_wr(8'h00, 32'h0010_0000, 4'hF);
    bus_wr(A_CTRL, 32'h0000_0003, 4'b0001);
    wait_req();
    checks++;
    if (tx_mb_idx !== 3'd0) begin
      failures++;
      $display("FAIL abort_win got=%0d exp=0", tx_mb_idx);
    end
    bus_wr(A_CTRL, 32'h0000_0300, 4'b0010);
    bus_wr(8'h00, 32'hDEAD_BEEF, 4'hF);
    bus_rd(A_STAT, d);
    checks++;
    if (d[7:0] !== 8'h01 || tx_req !== 1'b1) begin
      failures++;
      $display("FAIL abort_pend got=%h/%b exp=01/1", d[7:0], tx_req);
    end
    finish_tx(3'd0);
    cyc(4);
    checks++;
    if (tx_req !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got=%b/%b exp=0/0", tx_req, irq);
    end
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h0500_0100) begin
      failures++;
      $display("FAIL abort_status got=%h exp=05000100", d);
    end
    bus_rd(8'h00, d);
    checks++;
    if (d !== 32'h0010_0000) begin
      failures++;
      $display("FAIL flight_wr_ign got=%h exp=00100000", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_wr(A_CTRL, 32'h0000_0004, 4'b0001);
    wait_req();
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_req !== 1'b0 || tx_msg_id !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid got=%b/%h exp=0/0", tx_req, tx_msg_id);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);
    bus_rd(A_STAT, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_status got=%h exp=00000000", d);
    end
    cyc(5);
    checks++;
    if (tx_req !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle got=%b/%b exp=0/0", tx_req, irq);
    end
    bus_rd(8'h20, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_mb got=%h exp=00000000", d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    reg_valid = 1'b0; reg_wr_en = 1'b0;
    reg_addr = 8'h0; reg_wstrb = 4'h0; reg_wdata = 32'h0;
    tx_ack = 1'b0; tx_done = 1'b0; tx_sts = 3'd0;
    test_reset();
    test_byte_write();
    test_unmapped();
    test_priority();
    test_tie();
    test_error();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
